// File: rtl/pck_inj_sched.sv
// pck_inj_sched: round-robin arbiter sharing one packet_injector port among NR requesters.
// Grants latch the winner's fields, pulse inj_pck_wr once, then idle one cycle.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      per-requester hold flag / one-hot pop
//   req_dest/size/data/vc/class  packed per-requester fields, slice i = requester i
//   inj_pck_wr, inj_*          write strobe and latched fields to the injector
//   inj_ready                  per-VC ready from the injector
//   sent_cnt / drop_cnt        issued packets (wraps) / dropped requests (saturates)
module pck_inj_sched #(
  parameter int NR     = 4,
  parameter int EAw    = 8,
  parameter int DATA_w = 64,
  parameter int SIZE_w = 5,
  parameter int V      = 2,
  parameter int Cw     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NR-1:0]        req_valid,
  output logic [NR-1:0]        req_ready,
  input  logic [NR*EAw-1:0]    req_dest,
  input  logic [NR*SIZE_w-1:0] req_size,
  input  logic [NR*DATA_w-1:0] req_data,
  input  logic [NR*V-1:0]      req_vc,
  input  logic [NR*Cw-1:0]     req_class,
  output logic                 inj_pck_wr,
  output logic [EAw-1:0]       inj_endp_addr,
  output logic [SIZE_w-1:0]    inj_size,
  output logic [DATA_w-1:0]    inj_data,
  output logic [V-1:0]         inj_vc,
  output logic [Cw-1:0]        inj_class,
  input  logic [V-1:0]         inj_ready,
  output logic [31:0]          sent_cnt,
  output logic [15:0]          drop_cnt
);

  localparam int PW = $clog2(NR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [EAw-1:0]    dest_q, dest_d;
  logic [SIZE_w-1:0] size_q, size_d;
  logic [DATA_w-1:0] data_q, data_d;
  logic [V-1:0]      vc_q, vc_d;
  logic [Cw-1:0]     cls_q, cls_d;
  logic [31:0]       sent_q, sent_d;
  logic [15:0]       drop_q, drop_d;

  logic [NR-1:0] bad;
  logic [NR-1:0] good;
  logic [NR-1:0] elig;

  // Malformed requests are eligible even when their VC is not ready,
  // so they get flushed instead of clogging the requester.
  for (genvar g = 0; g < NR; g++) begin : g_req
    logic [V-1:0]      vc;
    logic [SIZE_w-1:0] sz;
    logic              onehot;
    assign vc      = req_vc[g*V +: V];
    assign sz      = req_size[g*SIZE_w +: SIZE_w];
    assign onehot  = (vc != '0) && ((vc & (vc - V'(1))) == '0);
    assign bad[g]  = (sz < SIZE_w'(2)) || !onehot;
    assign good[g] = !bad[g] && ((vc & inj_ready) != '0);
    assign elig[g] = req_valid[g] && (bad[g] || good[g]);
  end

  logic          any;
  logic [PW-1:0] win;

  // First eligible index at or after rr_ptr, wrapping modulo NR.
  always_comb begin : p_arb
    int idx;
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < NR; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NR) idx = idx - NR;
      if (!any && elig[idx[PW-1:0]]) begin
        any = 1'b1;
        win = idx[PW-1:0];
      end
    end
  end

  logic grant;
  assign grant = (state_q == IDLE) && any && !reset;

  assign req_ready = grant ? (NR'(1) << win) : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    dest_d   = dest_q;
    size_d   = size_q;
    data_d   = data_q;
    vc_d     = vc_q;
    cls_d    = cls_q;
    sent_d   = sent_q;
    drop_d   = drop_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          dest_d   = req_dest[int'(win)*EAw +: EAw];
          size_d   = req_size[int'(win)*SIZE_w +: SIZE_w];
          data_d   = req_data[int'(win)*DATA_w +: DATA_w];
          vc_d     = req_vc[int'(win)*V +: V];
          cls_d    = req_class[int'(win)*Cw +: Cw];
          rr_ptr_d = (win == PW'(NR-1)) ? '0 : win + PW'(1);
          if (bad[win]) begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        sent_d  = sent_q + 32'd1;
        state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      dest_q   <= '0;
      size_q   <= '0;
      data_q   <= '0;
      vc_q     <= '0;
      cls_q    <= '0;
      sent_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      dest_q   <= dest_d;
      size_q   <= size_d;
      data_q   <= data_d;
      vc_q     <= vc_d;
      cls_q    <= cls_d;
      sent_q   <= sent_d;
      drop_q   <= drop_d;
    end
  end

  assign inj_pck_wr    = (state_q == ISSUE);
  assign inj_endp_addr = dest_q;
  assign inj_size      = size_q;
  assign inj_data      = data_q;
  assign inj_vc        = vc_q;
  assign inj_class     = cls_q;
  assign sent_cnt      = sent_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_pck_inj_sched.sv
// tb_pck_inj_sched: directed and random stimulus against a behavioural
// scheduler model, compared on every falling edge.
`timescale 1ns/1ps
module tb_pck_inj_sched;

  localparam int NR     = 4;
  localparam int EAw    = 8;
  localparam int DATA_w = 64;
  localparam int SIZE_w = 5;
  localparam int V      = 2;
  localparam int Cw     = 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NR-1:0]        req_valid = '0;
  logic [NR-1:0]        req_ready;
  logic [NR*EAw-1:0]    req_dest = '0;
  logic [NR*SIZE_w-1:0] req_size = '0;
  logic [NR*DATA_w-1:0] req_data = '0;
  logic [NR*V-1:0]      req_vc = '0;
  logic [NR*Cw-1:0]     req_class = '0;
  logic                 inj_pck_wr;
  logic [EAw-1:0]       inj_endp_addr;
  logic [SIZE_w-1:0]    inj_size;
  logic [DATA_w-1:0]    inj_data;
  logic [V-1:0]         inj_vc;
  logic [Cw-1:0]        inj_class;
  logic [V-1:0]         inj_ready = 2'b11;
  logic [31:0]          sent_cnt;
  logic [15:0]          drop_cnt;

  always #5 clk = ~clk;

  pck_inj_sched #(
    .NR(NR), .EAw(EAw), .DATA_w(DATA_w),
    .SIZE_w(SIZE_w), .V(V), .Cw(Cw)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_size(req_size),
    .req_data(req_data), .req_vc(req_vc),
    .req_class(req_class),
    .inj_pck_wr(inj_pck_wr),
    .inj_endp_addr(inj_endp_addr),
    .inj_size(inj_size), .inj_data(inj_data),
    .inj_vc(inj_vc), .inj_class(inj_class),
    .inj_ready(inj_ready),
    .sent_cnt(sent_cnt), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 free, 1 packet on the wire, 2 recovery.
  int             m_phase = 0;
  int             m_ptr = 0;
  logic [EAw-1:0] m_dest = '0;
  logic [SIZE_w-1:0] m_size = '0;
  logic [DATA_w-1:0] m_data = '0;
  logic [V-1:0]   m_vc = '0;
  logic [Cw-1:0]  m_cls = '0;
  logic [31:0]    m_sent = '0;
  int             m_drop = 0;
  bit             armed = 1'b0;
  int             cyc = 0;
  int             glog[$];
  int             gcyc[$];
  logic [NR-1:0]  popped = '0;

  function automatic bit is_bad(int i);
    logic [V-1:0] vc;
    vc = req_vc[i*V +: V];
    return (req_size[i*SIZE_w +: SIZE_w] < 2) || ($countones(vc) != 1);
  endfunction

  function automatic bit is_ok(int i);
    return !is_bad(i) && ((req_vc[i*V +: V] & inj_ready) != '0);
  endfunction

  initial forever begin
    int w;
    logic [NR-1:0] er;
    @(negedge clk);
    cyc++;
    if (reset) armed = 1'b1;
    w = -1;
    er = '0;
    if (!reset && m_phase == 0)
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (w < 0 && req_valid[j] && (is_bad(j) || is_ok(j))) w = j;
      end
    if (w >= 0) er[w] = 1'b1;
    if (armed) begin
      chk("req_ready", req_ready, er);
      chk("pck_wr", inj_pck_wr, m_phase == 1);
      chk("endp_addr", inj_endp_addr, m_dest);
      chk("size", inj_size, m_size);
      chk("data", inj_data, m_data);
      chk("vc", inj_vc, m_vc);
      chk("class", inj_class, m_cls);
      chk("sent_cnt", sent_cnt, m_sent);
      chk("drop_cnt", drop_cnt, m_drop);
    end
    popped = req_valid & req_ready;
    if (reset) begin
      m_phase = 0; m_ptr = 0;
      m_dest = '0; m_size = '0; m_data = '0;
      m_vc = '0; m_cls = '0;
      m_sent = '0; m_drop = 0;
    end else if (m_phase == 1) begin
      m_sent = m_sent + 1;
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (w >= 0) begin
      glog.push_back(w);
      gcyc.push_back(cyc);
      m_dest = req_dest[w*EAw +: EAw];
      m_size = req_size[w*SIZE_w +: SIZE_w];
      m_data = req_data[w*DATA_w +: DATA_w];
      m_vc   = req_vc[w*V +: V];
      m_cls  = req_class[w*Cw +: Cw];
      m_ptr  = (w + 1) % NR;
      if (is_bad(w)) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        m_phase = 1;
      end
    end
  end

  // 0: withdraw on pop, 1: keep requesting, 2: random traffic
  int mode = 0;

  task automatic set_pkt(int i, int dest, int size, logic [63:0] data,
                         int vc, int cls);
    req_valid[i] = 1'b1;
    req_dest[i*EAw +: EAw] = EAw'(dest);
    req_size[i*SIZE_w +: SIZE_w] = SIZE_w'(size);
    req_data[i*DATA_w +: DATA_w] = data;
    req_vc[i*V +: V] = V'(vc);
    req_class[i*Cw +: Cw] = Cw'(cls);
  endtask

  task automatic rand_pkt(int i);
    int r;
    int vc;
    r = $urandom_range(0, 9);
    vc = (r < 4) ? 1 : (r < 8) ? 2 : (r == 8) ? 3 : 0;
    set_pkt(i, $urandom_range(0, 255), $urandom_range(0, 31),
            {$urandom, $urandom}, vc, $urandom_range(0, 1));
  endtask

  task automatic refill();
    for (int i = 0; i < NR; i++) begin
      if (mode == 0 && popped[i]) req_valid[i] = 1'b0;
      if (mode == 2 && (popped[i] || !req_valid[i])) begin
        if ($urandom_range(0, 9) < 6) rand_pkt(i);
        else req_valid[i] = 1'b0;
      end
    end
    if (mode == 2) begin
      if ($urandom_range(0, 3) == 0) inj_ready = V'($urandom_range(0, 3));
      reset = ($urandom_range(0, 199) == 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic half();
    @(negedge clk);
    #1;
  endtask

  task automatic cycle();
    step();
    half();
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_glog(int target, int limit, string nm);
    int c;
    c = 0;
    while (glog.size() < target && c < limit) begin
      cycle();
      c++;
    end
    chk(nm, glog.size() >= target, 1);
  endtask

  int base;

  initial begin
    // reset with everyone requesting
    for (int i = 0; i < NR; i++) set_pkt(i, i, 4, 64'(i), 1, 0);
    repeat (3) begin
      half();
      chk("rst ready", req_ready, 0);
      chk("rst wr", inj_pck_wr, 0);
      chk("rst sent", sent_cnt, 0);
      chk("rst drop", drop_cnt, 0);
    end
    step();
    reset = 1'b0;
    req_valid = '0;

    // single packet
    step();
    inj_ready = 2'b11;
    set_pkt(1, 0, 3, 64'h0123456789ABCDEF, 1, 0);
    half();
    chk("t2 ready", req_ready, 4'b0010);
    cycle();
    chk("t2 wr", inj_pck_wr, 1);
    chk("t2 data", inj_data, 64'h0123456789ABCDEF);
    chk("t2 size", inj_size, 3);
    chk("t2 vc", inj_vc, 2'b01);
    chk("t2 dest", inj_endp_addr, 0);
    cycle();
    chk("t2 wr low", inj_pck_wr, 0);
    chk("t2 sent", sent_cnt, 1);

    // round robin over 12 grants
    do_reset();
    mode = 1;
    for (int i = 0; i < NR; i++) set_pkt(i, 16 + i, 2 + i, 64'(100 + i), 2, 1);
    base = glog.size();
    half();
    wait_glog(base + 12, 100, "rr timeout");
    step();
    mode = 0;
    req_valid = '0;
    half();
    if (glog.size() >= base + 12) begin
      for (int k = 0; k < 12; k++) chk("rr order", glog[base + k], k % 4);
      for (int k = 1; k < 12; k++)
        chk("rr spacing", gcyc[base + k] - gcyc[base + k - 1], 3);
    end
    repeat (3) cycle();
    chk("rr sent", sent_cnt, 12);
    chk("rr drop", drop_cnt, 0);

    // VC blocking
    step();
    inj_ready = 2'b10;
    set_pkt(0, 5, 4, 64'hAAAA, 1, 0);
    set_pkt(2, 6, 5, 64'hBBBB, 2, 1);
    base = glog.size();
    half();
    wait_glog(base + 1, 20, "vc first timeout");
    repeat (8) cycle();
    chk("vc blocked count", glog.size(), base + 1);
    if (glog.size() > base) chk("vc first", glog[base], 2);
    step();
    inj_ready = 2'b11;
    half();
    wait_glog(base + 2, 20, "vc second timeout");
    if (glog.size() > base + 1) chk("vc second", glog[base + 1], 0);
    repeat (4) cycle();

    // malformed requests
    step();
    set_pkt(3, 7, 1, 64'h1, 1, 0);
    base = glog.size();
    half();
    wait_glog(base + 1, 20, "bad1 timeout");
    step();
    set_pkt(3, 8, 6, 64'h2, 3, 0);
    half();
    wait_glog(base + 2, 20, "bad2 timeout");
    repeat (3) cycle();
    chk("bad drop", drop_cnt, 2);
    chk("bad sent", sent_cnt, 14);
    chk("bad wr", inj_pck_wr, 0);
    if (glog.size() >= base + 2) begin
      chk("bad who1", glog[base], 3);
      chk("bad who2", glog[base + 1], 3);
      chk("bad spacing", gcyc[base + 1] - gcyc[base], 1);
    end

    // reset during ISSUE
    step();
    mode = 1;
    set_pkt(2, 9, 4, 64'hC0DE, 2, 0);
    base = glog.size();
    half();
    wait_glog(base + 1, 20, "r6 timeout");
    step();
    reset = 1'b1;
    set_pkt(1, 10, 4, 64'hF00D, 1, 1);
    half();
    chk("r6 issue", inj_pck_wr, 1);
    step();
    reset = 1'b0;
    half();
    chk("r6 wr", inj_pck_wr, 0);
    chk("r6 sent", sent_cnt, 0);
    chk("r6 ready", req_ready, 4'b0010);
    if (glog.size() >= base + 2) chk("r6 winner", glog[base + 1], 1);
    step();
    mode = 0;
    half();
    repeat (8) cycle();

    // random traffic
    step();
    mode = 2;
    half();
    repeat (3000) cycle();
    step();
    mode = 0;
    reset = 1'b0;
    inj_ready = 2'b11;
    half();
    repeat (30) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pck_inj_sched.md
# pck_inj_sched

Round-robin scheduler that lets NR local requesters share one `packet_injector` port. It sits between the endpoint-side packet sources and the injector's `pck_injct_in`/`pck_injct_out` control interface. It selects one eligible packet and latches its fields. It then drives a single-cycle `pck_wr` pulse followed by the mandatory idle cycle. Malformed requests are dropped and counted.

## Interface
- `NR`, 4: number of requesters, 2..16.
- `EAw`, 8: endpoint address width; matches injector `endp_addr`.
- `DATA_w`, 64: packet data width.
- `SIZE_w`, 5: packet size field width, in flits.
- `V`, 2: number of VCs; matches the width of injector `ready`/`vc`.
- `Cw`, 1: class field width.

Ports:
- `clk`  in  1: clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  NR: requester i holds a packet.
- `req_ready`  out  NR: one-hot pop to the granted requester.
- `req_dest`  in  NR*EAw: destination endpoint address; slice i belongs to requester i.
- `req_size`  in  NR*SIZE_w: packet size in flits.
- `req_data`  in  NR*DATA_w: packet payload.
- `req_vc`  in  NR*V: requested VC, one-hot.
- `req_class`  in  NR*Cw: message class.
- `inj_pck_wr`  out  1: packet write strobe to the injector.
- `inj_endp_addr`  out  EAw: latched destination.
- `inj_size`  out  SIZE_w: latched size.
- `inj_data`  out  DATA_w: latched payload.
- `inj_vc`  out  V: latched VC.
- `inj_class`  out  Cw: latched class.
- `inj_ready`  in  V: per-VC ready from the injector.
- `sent_cnt`  out  32: packets issued; wraps at 2^32.
- `drop_cnt`  out  16: requests dropped; saturates at 0xFFFF.

## Operation
- **Validity.** A request is valid when `req_size` >= 2, `req_vc` is one-hot, and its bit is set in `inj_ready`.
- **Eligibility.** Requester i is eligible when `req_valid[i]` is high and its request is valid.
- **Malformed request.** This means size < 2, or `req_vc` zero or with more than one bit set.
  - A malformed request is eligible regardless of `inj_ready`.
  - When granted, it is popped and discarded: no ISSUE, `drop_cnt`+1, and the FSM returns to IDLE the next cycle.
- **Arbitration.**
  - Round robin, starting from pointer `rr_ptr`; the first eligible index at or after `rr_ptr` wins, wrapping modulo NR.
  - On a grant, `rr_ptr` becomes winner+1, wrapping to 0 after NR-1.
- **FSM states:** IDLE, ISSUE, GAP.
  - **IDLE.** If any requester is eligible, `req_ready[w]` goes high combinationally in the same cycle, and all fields of w are latched at the edge.
    - Valid request: go to ISSUE.
    - Malformed request: stay in IDLE and count the drop.
    - No eligible requester: `req_ready` = 0.
  - **ISSUE.** `inj_pck_wr` = 1 for exactly one cycle with the latched fields; `sent_cnt`+1 at the end of the cycle. Go to GAP.
  - **GAP.** `inj_pck_wr` = 0 so the injector can update `ready`; `req_ready` = 0. Go to IDLE.
- **Output stability.** `inj_*` fields keep their latched values outside ISSUE; only the `pck_wr` strobe is meaningful.
- **`inj_ready` during ISSUE/GAP.** It is not re-checked after the grant; eligibility was already decided in IDLE.

## Timing
- **Reset values.** `reset` = 1 at an edge gives:
  - state IDLE, `rr_ptr` = 0;
  - `inj_pck_wr` = 0, `inj_endp_addr` / `inj_size` / `inj_data` / `inj_vc` / `inj_class` = 0;
  - `sent_cnt` = 0, `drop_cnt` = 0;
  - `req_ready` = 0 while `reset` is high.
- **Reset mid-operation.** A latched, unissued packet is lost; it is not counted.
- **Latency.** A grant in cycle t gives `inj_pck_wr` in t+1 and GAP in t+2; the next grant is possible in t+3.
- **Throughput.** Peak throughput is 1 packet per 3 cycles; a dropped request costs 1 cycle.
- **Handshake.** A requester must hold `req_valid` and its fields stable until `req_ready` is seen; the pop is `req_valid & req_ready` in the same cycle.
- **Simultaneous requests.** With all NR requesting, service order from reset is 0, 1, ..., NR-1, 0, ...
- **Blocked VC.** A requester whose VC is not ready is skipped; it does not block others and its pointer position is not reserved.

## Test plan
1. **Reset state.** Hold `reset` 3 cycles with all `req_valid` high → `req_ready` = 0, `inj_pck_wr` = 0, both counters 0.
2. **Single packet.** Requester 1: dest = 0, size = 3, data = 0x123456789ABCDEF, vc = 2'b01, with `inj_ready` = 2'b11.
   - Expect `req_ready` = 4'b0010 at t and `inj_pck_wr` at t+1 with identical fields.
   - Expect `inj_pck_wr` low at t+2 and `sent_cnt` = 1.
3. **Round-robin fairness.** All 4 requesters continuously valid for 12 grants → grant order 0, 1, 2, 3 repeated 3 times, 3-cycle spacing, `sent_cnt` = 12.
4. **VC blocking.** Requester 0 wants vc 2'b01 and requester 2 wants 2'b10, with `inj_ready` = 2'b10.
   - Expect only requester 2 to be served.
   - After `inj_ready` = 2'b11, requester 0 is served next.
5. **Malformed requests.** Requester 3 sends size = 1, then vc = 2'b11 → two single-cycle pops, no `inj_pck_wr`, `drop_cnt` = 2.
6. **Reset during ISSUE.** Assert `reset` in the ISSUE cycle → `inj_pck_wr` = 0 at the next edge, `sent_cnt` = 0; the first post-reset grant goes to the lowest valid index.
